// File: rtl/instr_reg_ctrl.sv
// instr_reg_ctrl: clocked sequencer driving the async instruction register.
// Fetches or debug-injects words, runs the 4-phase IR handshake, flags timeouts.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   start, halt          run control (pulse / level)
//   pc_load, pc_in       PC preset, honoured only in IDLE
//   mem_rd, mem_addr     fetch request (held until mem_valid), address = pc
//   mem_valid, mem_data  fetch response, same cycle
//   dbg_req, dbg_instr   debug word request (level) and word
//   dbg_gnt              1-cycle pulse once the debug word is captured
//   ir_data, ir_ph       word and phase code to the IR
//   ir_ack_next          request to the IR (0 = present, 1 = release)
//   ir_ack_befo          async acknowledge from the IR
//   pc, busy, tmo_err    status
module instr_reg_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int TMO_CYC = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [15:0]       mem_data,
  input  logic              dbg_req,
  input  logic [15:0]       dbg_instr,
  output logic              dbg_gnt,
  output logic [15:0]       ir_data,
  output logic [1:0]        ir_ph,
  output logic              ir_ack_next,
  input  logic              ir_ack_befo,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              tmo_err
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    PRESENT,
    RELEASE,
    ERR
  } state_t;

  localparam logic [3:0] TMO_LAST = 4'(TMO_CYC - 1);

  state_t      state;
  logic [15:0] word;
  logic [3:0]  tmo_cnt;
  logic        ack_m;
  logic        ack_s;
  logic        tmo_hit;

  assign mem_addr = pc;
  assign tmo_hit  = (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_m <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      ack_m <= ir_ack_befo;
      ack_s <= ack_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      word        <= '0;
      tmo_cnt     <= '0;
      pc          <= '0;
      mem_rd      <= 1'b0;
      dbg_gnt     <= 1'b0;
      ir_data     <= '0;
      ir_ph       <= 2'b11;
      ir_ack_next <= 1'b1;
      busy        <= 1'b0;
      tmo_err     <= 1'b0;
    end else begin
      dbg_gnt <= 1'b0;
      tmo_cnt <= tmo_cnt + 4'd1;
      unique case (state)
        IDLE: begin
          if (pc_load) pc <= pc_in;
          if (dbg_req) begin
            state       <= PRESENT;
            word        <= dbg_instr;
            ir_data     <= dbg_instr;
            ir_ph       <= dbg_instr[15:14];
            ir_ack_next <= 1'b0;
            tmo_cnt     <= '0;
            dbg_gnt     <= 1'b1;
            busy        <= 1'b1;
          end else if (start) begin
            state  <= FETCH;
            mem_rd <= 1'b1;
            busy   <= 1'b1;
          end
        end
        FETCH: begin
          if (mem_valid) begin
            state       <= PRESENT;
            word        <= mem_data;
            ir_data     <= mem_data;
            ir_ph       <= mem_data[15:14];
            ir_ack_next <= 1'b0;
            tmo_cnt     <= '0;
            mem_rd      <= 1'b0;
            pc          <= pc + ADDR_W'(1);
          end
        end
        PRESENT: begin
          if (ack_s) begin
            state       <= RELEASE;
            ir_ph       <= ~word[15:14];
            ir_ack_next <= 1'b1;
            tmo_cnt     <= '0;
          end else if (tmo_hit) begin
            state       <= ERR;
            ir_ph       <= ~word[15:14];
            ir_ack_next <= 1'b1;
            tmo_err     <= 1'b1;
          end
        end
        RELEASE: begin
          if (!ack_s) begin
            if (dbg_req) begin
              state       <= PRESENT;
              word        <= dbg_instr;
              ir_data     <= dbg_instr;
              ir_ph       <= dbg_instr[15:14];
              ir_ack_next <= 1'b0;
              tmo_cnt     <= '0;
              dbg_gnt     <= 1'b1;
            end else if (halt) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state  <= FETCH;
              mem_rd <= 1'b1;
            end
          end else if (tmo_hit) begin
            state   <= ERR;
            tmo_err <= 1'b1;
          end
        end
        ERR: begin
          // IR must have dropped its ack before we let go.
          if (start && !ack_s) begin
            state   <= IDLE;
            tmo_err <= 1'b0;
            busy    <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          mem_rd      <= 1'b0;
          ir_ack_next <= 1'b1;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_reg_ctrl.sv
// tb_instr_reg_ctrl: directed + random bench for instr_reg_ctrl.
// Word-level scoreboard, memory and IR models, per-cycle invariants.
module tb_instr_reg_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic        pc_load = 1'b0;
  logic [7:0]  pc_in = '0;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic        mem_valid = 1'b0;
  logic [15:0] mem_data = '0;
  logic        dbg_req = 1'b0;
  logic [15:0] dbg_instr = '0;
  logic        dbg_gnt;
  logic [15:0] ir_data;
  logic [1:0]  ir_ph;
  logic        ir_ack_next;
  logic        ir_ack_befo = 1'b0;
  logic [7:0]  pc;
  logic        busy;
  logic        tmo_err;

  int tests = 0;
  int fails = 0;

  logic [15:0] mem [256];
  int mem_lat = 0;
  int m_cnt = 0;
  int ir_lat = 0;
  int ir_cnt = 0;
  int ir_mode = 0;

  logic [15:0] exp_q[$];
  logic [7:0]  exp_pc = '0;
  logic        prev_ack = 1'b1;
  int cyc = 0;
  int pres_cyc = 0;
  int pres_gap = 0;
  int pres_n = 0;
  int dbg_reqs = 0;
  int dbg_gnts = 0;

  instr_reg_ctrl #(.ADDR_W(8), .TMO_CYC(15)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .halt(halt),
    .pc_load(pc_load),
    .pc_in(pc_in),
    .mem_rd(mem_rd),
    .mem_addr(mem_addr),
    .mem_valid(mem_valid),
    .mem_data(mem_data),
    .dbg_req(dbg_req),
    .dbg_instr(dbg_instr),
    .dbg_gnt(dbg_gnt),
    .ir_data(ir_data),
    .ir_ph(ir_ph),
    .ir_ack_next(ir_ack_next),
    .ir_ack_befo(ir_ack_befo),
    .pc(pc),
    .busy(busy),
    .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // memory: answers mem_rd after mem_lat extra cycles
  always @(posedge clk) begin
    #2;
    if (!mem_rd) begin
      mem_valid = 1'b0;
      m_cnt = 0;
    end else if (m_cnt >= mem_lat) begin
      mem_valid = 1'b1;
    end else begin
      mem_valid = 1'b0;
      m_cnt++;
    end
    mem_data = mem_valid ? mem[mem_addr] : 16'($urandom);
  end

  // IR: ack_befo follows ~ack_next after ir_lat cycles
  // mode 1 never acks, mode 2 never releases
  always @(posedge clk) begin
    #1;
    if (ir_ack_befo != ir_ack_next ||
        (ir_mode == 1 && !ir_ack_next) ||
        (ir_mode == 2 && ir_ack_next))
      ir_cnt = 0;
    else if (ir_cnt >= ir_lat) begin
      ir_ack_befo = ~ir_ack_next;
      ir_cnt = 0;
    end else
      ir_cnt++;
  end

  // word scoreboard and per-cycle invariants
  always @(negedge clk) begin
    logic [1:0] eph;
    if (!rst_n) begin
      exp_q.delete();
      exp_pc = '0;
      prev_ack = 1'b1;
    end else begin
      check("pc", pc, exp_pc);
      check("mem_addr", mem_addr, exp_pc);
      eph = ir_ack_next ? ~ir_data[15:14] : ir_data[15:14];
      check("ir_ph", ir_ph, eph);
      if (dbg_gnt) begin
        exp_q.push_back(dbg_instr);
        dbg_gnts++;
      end
      if (prev_ack && !ir_ack_next) begin
        check("word_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0)
          check("ir_data", ir_data, exp_q.pop_front());
        pres_gap = cyc - pres_cyc;
        pres_cyc = cyc;
        pres_n++;
      end
      prev_ack = ir_ack_next;
      if (mem_rd && mem_valid) begin
        exp_q.push_back(mem[exp_pc]);
        exp_pc = exp_pc + 8'd1;
      end
      if (pc_load && !busy) exp_pc = pc_in;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_pres(input string name);
    int p0;
    int n;
    p0 = pres_n;
    n = 0;
    while (pres_n == p0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({name, "_present"}, pres_n != p0, 1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check({name, "_idle"}, busy, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int n;
    int p0;
    logic [7:0] p_save;
    logic [1:0] eph;

    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[8'h10] = 16'h4ABC;
    mem[8'hFF] = 16'h8001;

    // reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst_ack_next", ir_ack_next, 1);
    check("rst_ir_ph", ir_ph, 2'b11);
    check("rst_ir_data", ir_data, 0);
    check("rst_pc", pc, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_dbg_gnt", dbg_gnt, 0);
    check("rst_tmo_err", tmo_err, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // fetch from 0x10, steady 7-cycle throughput
    pc_in = 8'h10;
    pc_load = 1'b1;
    tick();
    pc_load = 1'b0;
    pulse_start();
    check("t1_mem_rd", mem_rd, 1);
    check("t1_mem_addr", mem_addr, 8'h10);
    wait_pres("t1a");
    check("t1_ir_data", ir_data, 16'h4ABC);
    check("t1_ir_ph", ir_ph, 2'b01);
    check("t1_pc", pc, 8'h11);
    wait_pres("t1b");
    wait_pres("t1c");
    check("t1_gap", pres_gap, 7);

    // debug word injected while a fetched word is in flight
    p_save = pc;
    tick();
    dbg_instr = 16'hC123;
    dbg_req = 1'b1;
    dbg_reqs++;
    n = 0;
    while (!dbg_gnt && n < 50) begin
      tick();
      n++;
    end
    dbg_req = 1'b0;
    check("t2_gnt_latency", n, 5);
    @(negedge clk);
    #1;
    check("t2_ir_data", ir_data, 16'hC123);
    check("t2_ir_ph", ir_ph, 2'b11);
    check("t2_ack_next", ir_ack_next, 0);
    check("t2_pc", pc, p_save);
    wait_pres("t2_next");
    check("t2_next_pc", pc, p_save + 8'd1);

    // halt during PRESENT: word completes, then idle, no fetch
    tick();
    halt = 1'b1;
    p0 = pres_n;
    wait_idle("t5");
    check("t5_words", pres_n - p0, 0);
    check("t5_ack_next", ir_ack_next, 1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_rd) n++;
    end
    check("t5_no_mem_rd", n, 0);
    check("t5_pc", pc, p_save + 8'd1);

    // IR never acks: timeout in PRESENT
    ir_mode = 1;
    tick();
    pulse_start();
    wait_pres("t3");
    n = 1;
    while (!ir_ack_next && n < 40) begin
      @(negedge clk);
      #1;
      if (!ir_ack_next) n++;
    end
    check("t3_tmo_cycles", n, 15);
    check("t3_tmo_err", tmo_err, 1);
    check("t3_ack_next", ir_ack_next, 1);
    check("t3_busy", busy, 1);
    eph = ~ir_data[15:14];
    check("t3_ir_ph", ir_ph, eph);
    repeat (5) tick();
    check("t3_err_held", tmo_err, 1);
    pulse_start();
    check("t3_exit_busy", busy, 0);
    check("t3_exit_tmo", tmo_err, 0);
    ir_mode = 0;

    // IR never releases: timeout in RELEASE, start blocked by ack
    ir_mode = 2;
    tick();
    pulse_start();
    wait_pres("t3b");
    n = 0;
    while (!tmo_err && n < 60) begin
      tick();
      n++;
    end
    check("t3b_tmo_err", tmo_err, 1);
    pulse_start();
    check("t3b_blocked_busy", busy, 1);
    check("t3b_blocked_tmo", tmo_err, 1);
    ir_mode = 0;
    repeat (5) tick();
    pulse_start();
    check("t3b_exit_busy", busy, 0);
    check("t3b_exit_tmo", tmo_err, 0);

    // PC wrap from 0xFF
    pc_in = 8'hFF;
    pc_load = 1'b1;
    tick();
    pc_load = 1'b0;
    pulse_start();
    wait_pres("t4");
    check("t4_ir_data", ir_data, 16'h8001);
    check("t4_ir_ph", ir_ph, 2'b10);
    check("t4_pc", pc, 8'h00);
    wait_idle("t4");

    // debug beats start in IDLE; start is dropped
    dbg_instr = 16'h3A5A;
    dbg_req = 1'b1;
    dbg_reqs++;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("td_gnt", dbg_gnt, 1);
    dbg_req = 1'b0;
    wait_idle("td");
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_rd) n++;
    end
    check("td_no_mem_rd", n, 0);
    check("td_pc", pc, 8'h00);

    // async reset mid-handshake
    halt = 1'b0;
    pulse_start();
    wait_pres("t6");
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_ack_next", ir_ack_next, 1);
    check("t6_ir_ph", ir_ph, 2'b11);
    check("t6_ir_data", ir_data, 0);
    check("t6_pc", pc, 0);
    check("t6_busy", busy, 0);
    check("t6_mem_rd", mem_rd, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      start = 1'b0;
      pc_load = 1'b0;
      if (dbg_req && dbg_gnt)
        dbg_req = 1'b0;
      else if (!dbg_req && $urandom_range(0, 24) == 0) begin
        dbg_instr = 16'($urandom);
        dbg_req = 1'b1;
        dbg_reqs++;
      end
      if (!busy && $urandom_range(0, 3) == 0) start = 1'b1;
      if ($urandom_range(0, 15) == 0) begin
        pc_load = 1'b1;
        pc_in = 8'($urandom);
      end
      if ($urandom_range(0, 40) == 0) halt = ~halt;
      if ($urandom_range(0, 50) == 0) mem_lat = $urandom_range(0, 3);
      if ($urandom_range(0, 50) == 0) ir_lat = $urandom_range(0, 3);
      check("rand_tmo_err", tmo_err, 0);
    end

    // drain
    start = 1'b0;
    pc_load = 1'b0;
    halt = 1'b1;
    n = 0;
    while ((busy || dbg_req) && n < 300) begin
      tick();
      if (dbg_req && dbg_gnt) dbg_req = 1'b0;
      n++;
    end
    check("end_busy", busy, 0);
    check("end_dbg_req", dbg_req, 0);
    check("end_queue", exp_q.size(), 0);
    check("end_gnts", dbg_gnts, dbg_reqs);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
